eth_preamble_rx: RTL

ETH_PREAMBLE_RX -- requirements
Module: eth_preamble_rx

---
 rtl/eth_preamble_rx_if.sv | 25 ++
 rtl/eth_preamble_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/eth_preamble_rx_if.sv
// RMII receive-side bundle: PHY dibit input plus the de-preambled dibit stream and frame status.
// The master side is the PHY/consumer; the slave side is the preamble stripper.
interface eth_preamble_rx_if #(
   parameter int MAX_FRAME_BYTES = 1522
);
   localparam int LW = $clog2(MAX_FRAME_BYTES + 1);

   logic          crs_dv;
   logic [1:0]    rxd;
   logic          outclk;
   logic [1:0]    out;
   logic          done;
   logic          err;
   logic [LW-1:0] frame_len;

   modport master (
      output crs_dv, rxd,
      input  outclk, out, done, err, frame_len
   );

   modport slave (
      input  crs_dv, rxd,
      output outclk, out, done, err, frame_len
   );
endinterface

// File: rtl/eth_preamble_rx.sv
// RMII preamble/SFD stripper: hunts 01...01 11, forwards post-SFD dibits one cycle late,
// and reports clean byte-aligned frame ends (done/frame_len) or rejections (err).
module eth_preamble_rx #(
   parameter int MIN_PREAMBLE    = 8,
   parameter int MAX_FRAME_BYTES = 1522
) (
   input  logic             clk,
   input  logic             rst,
   eth_preamble_rx_if.slave bus
);
   localparam int              LW    = $clog2(MAX_FRAME_BYTES + 1);
   localparam logic [6:0]      MIN_C = 7'(MIN_PREAMBLE);
   localparam logic [LW-1:0]   MAX_C = LW'(MAX_FRAME_BYTES);

   typedef enum logic [1:0] {SKIP = 2'd0, IDLE = 2'd1, PREAMBLE = 2'd2, BODY = 2'd3} state_t;

   state_t        state_reg, state_next;
   logic          low_reg, low_next;
   logic [5:0]    pre_cnt_reg, pre_cnt_next;
   logic          phase_reg, phase_next;
   logic          pend_reg, pend_next;
   logic          fin_reg, fin_next;
   logic [1:0]    dib_cnt_reg, dib_cnt_next;
   logic [LW-1:0] byte_cnt_reg, byte_cnt_next;
   logic          strobe_reg, strobe_next;
   logic [1:0]    data_reg, data_next;
   logic          done_reg, done_next;
   logic          err_reg, err_next;
   logic [LW-1:0] frame_len_reg, frame_len_next;

   logic          pre_err, emit_ev, cap_ev, end_ev, abort_ev;
   logic [5:0]    pre_c;
   logic [1:0]    dc;
   logic [LW-1:0] bc;
   logic          at_max, good_end, late_emit;

   // A new dibit arriving with a full byte count would overflow the frame.
   assign at_max   = (dib_cnt_reg == 2'd0) && (byte_cnt_reg == MAX_C);
   assign good_end = (dib_cnt_reg == 2'd0) && (byte_cnt_reg != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= SKIP;
         low_reg       <= 1'b0;
         pre_cnt_reg   <= '0;
         phase_reg     <= 1'b0;
         pend_reg      <= 1'b0;
         fin_reg       <= 1'b0;
         dib_cnt_reg   <= '0;
         byte_cnt_reg  <= '0;
         strobe_reg    <= 1'b0;
         data_reg      <= '0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         frame_len_reg <= '0;
      end else begin
         state_reg     <= state_next;
         low_reg       <= low_next;
         pre_cnt_reg   <= pre_cnt_next;
         phase_reg     <= phase_next;
         pend_reg      <= pend_next;
         fin_reg       <= fin_next;
         dib_cnt_reg   <= dib_cnt_next;
         byte_cnt_reg  <= byte_cnt_next;
         strobe_reg    <= strobe_next;
         data_reg      <= data_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
         frame_len_reg <= frame_len_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      low_next      = low_reg;
      pre_cnt_next  = pre_cnt_reg;
      phase_next    = phase_reg;
      pend_next     = 1'b0;
      fin_next      = 1'b0;
      dib_cnt_next  = dib_cnt_reg;
      byte_cnt_next = byte_cnt_reg;
      pre_err       = 1'b0;
      emit_ev       = 1'b0;
      cap_ev        = 1'b0;
      end_ev        = 1'b0;
      abort_ev      = 1'b0;
      dc            = dib_cnt_reg;
      bc            = byte_cnt_reg;
      pre_c         = (state_reg == PREAMBLE) ? pre_cnt_reg : 6'd0;
      unique case (state_reg)
         SKIP: begin
            if (bus.crs_dv) begin
               low_next = 1'b0;
            end else if (low_reg) begin
               state_next = IDLE;
               low_next   = 1'b0;
            end else begin
               low_next = 1'b1;
            end
         end
         IDLE, PREAMBLE: begin
            if (!bus.crs_dv) begin
               state_next = IDLE;
            end else begin
               state_next   = PREAMBLE;
               pre_cnt_next = pre_c;
               case (bus.rxd)
                  2'b01: pre_cnt_next = (pre_c == 6'd63) ? pre_c : pre_c + 6'd1;
                  2'b00: pre_err = (pre_c != 6'd0);
                  2'b11: begin
                     if ({1'b0, pre_c} >= MIN_C) begin
                        state_next    = BODY;
                        phase_next    = 1'b0;
                        dib_cnt_next  = '0;
                        byte_cnt_next = '0;
                     end else begin
                        pre_err = 1'b1;
                     end
                  end
                  default: pre_err = 1'b1;
               endcase
               if (pre_err) begin
                  state_next = SKIP;
                  low_next   = 1'b0;
               end
            end
         end
         BODY: begin
            if (fin_reg) begin
               state_next = bus.crs_dv ? SKIP : IDLE;
               low_next   = 1'b0;
            end else begin
               phase_next = ~phase_reg;
               // A pending phase-0 low dibit is resolved by this cycle's crs_dv; if valid,
               // it and the current dibit are both counted here.
               if (pend_reg) begin
                  if (!bus.crs_dv) begin
                     end_ev = 1'b1;
                  end else if (at_max) begin
                     abort_ev = 1'b1;
                  end else begin
                     if (dc == 2'd3) bc = bc + 1'b1;
                     dc = dc + 2'd1;
                     if ((dc == 2'd0) && (bc == MAX_C)) begin
                        abort_ev = 1'b1;
                     end else begin
                        if (dc == 2'd3) bc = bc + 1'b1;
                        dc      = dc + 2'd1;
                        emit_ev = 1'b1;
                        cap_ev  = 1'b1;
                     end
                  end
               end else if (bus.crs_dv) begin
                  if (at_max) begin
                     abort_ev = 1'b1;
                  end else begin
                     if (dc == 2'd3) bc = bc + 1'b1;
                     dc      = dc + 2'd1;
                     emit_ev = 1'b1;
                     cap_ev  = 1'b1;
                  end
               end else if (phase_reg) begin
                  end_ev = 1'b1;
               end else begin
                  pend_next = 1'b1;
                  cap_ev    = 1'b1;
               end
               fin_next      = end_ev;
               dib_cnt_next  = dc;
               byte_cnt_next = bc;
               if (abort_ev) begin
                  state_next = SKIP;
                  low_next   = 1'b0;
               end
            end
         end
      endcase
   end

   always_comb begin
      strobe_next    = emit_ev;
      data_next      = cap_ev ? bus.rxd : 2'b00;
      done_next      = end_ev & good_end;
      err_next       = pre_err | abort_ev | (end_ev & ~good_end);
      frame_len_next = (end_ev & good_end) ? byte_cnt_reg : frame_len_reg;
   end

   // A held phase-0 dibit confirmed by crs_dv going high is forwarded in the confirming cycle.
   assign late_emit     = (state_reg == BODY) & pend_reg & ~fin_reg & bus.crs_dv & ~at_max;
   assign bus.outclk    = strobe_reg | late_emit;
   assign bus.out       = bus.outclk ? data_reg : 2'b00;
   assign bus.done      = done_reg;
   assign bus.err       = err_reg;
   assign bus.frame_len = frame_len_reg;
endmodule
